program_run_checker: RTL and testbench
======================================

Name: program_run_checker

Overview:
Synthesizable successor to the fixed-delay program test harness. It sits beside an Abejaruco core and does three jobs:
- counts core cycles with a parametrised-width counter;
- detects program completion (PC parked at END_PC) or a timeout;
- reads a BUF_DEPTH-word result buffer through a handshake read port, sums it, and reports pass/fail against an expected value.
It replaces the fixed #100 wait with a bounded, self-checking run.

Parameters:
DATA_WIDTH, 32, width of memory data words and of the sum
ADDR_WIDTH, 32, width of PC and memory address
CYCLE_WIDTH, 16, width of cycle counter
TIMEOUT, 1000, cycles in RUN before timeout is declared (1..2^CYCLE_WIDTH-1)
STALL_LIMIT, 4, consecutive cycles with pc==END_PC that mean halt (>=1)
END_PC, 32'h0000_0100, PC value of the program's final self-loop
BUF_BASE, 32'h0000_0000, byte address of buffer word 0
BUF_DEPTH, 8, number of words to sum (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: begin a run (accepted in IDLE or DONE only)
pc  input  ADDR_WIDTH  core program counter, sampled every clk
mem_req  output  1  read request, held until accepted
mem_addr  output  ADDR_WIDTH  read byte address, stable while mem_req=1
mem_ready  input  1  read accepted; mem_data valid this cycle
mem_data  input  DATA_WIDTH  read data
expected_sum  input  DATA_WIDTH  reference sum, sampled when start is accepted
busy  output  1  high in RUN, SCAN
done  output  1  high in DONE
pass  output  1  valid when done: sum==expected and no timeout
timed_out  output  1  valid when done: run ended by timeout
cycle_count  output  CYCLE_WIDTH  cycles spent in RUN
sum  output  DATA_WIDTH  running/final buffer sum

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. mem_req, busy, done, pass, timed_out = 0. cycle_count, sum, mem_addr, word index, stall counter = 0. Reset mid-run aborts immediately; no partial result is kept.
- States: IDLE, RUN, SCAN, DONE.
- IDLE/DONE + start:
  - go to RUN next cycle;
  - clear cycle_count, sum, stall counter, pass, timed_out, done;
  - latch expected_sum.
- start while busy: ignored.
- RUN:
  - cycle_count += 1 per cycle, saturating at all-ones.
  - Stall counter increments when pc==END_PC and clears otherwise.
  - When the stall counter reaches STALL_LIMIT, go to SCAN next cycle.
  - If cycle_count reaches TIMEOUT-1 in that cycle instead, go to DONE with timed_out=1, pass=0, no scan.
  - Halt and timeout in the same cycle: halt wins.
- SCAN:
  - mem_req=1, mem_addr = BUF_BASE + 4*idx (idx from 0); address arithmetic wraps mod 2^ADDR_WIDTH.
  - On mem_ready: sum <= sum + mem_data (wraps mod 2^DATA_WIDTH), idx += 1, mem_addr advances on the next cycle.
  - mem_req may stay high back-to-back, giving 1 word/cycle with mem_ready tied high.
  - After word BUF_DEPTH-1 is accepted: mem_req=0 next cycle, go to DONE.
  - cycle_count is frozen in SCAN; there is no timeout in SCAN.
- DONE:
  - done=1, busy=0.
  - pass = (sum == latched expected) && !timed_out, registered on entry.
  - All outputs hold until start or reset.
- Latency with zero-wait memory: DONE is reached STALL_LIMIT + BUF_DEPTH + 1 cycles after END_PC is first seen.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset held low for 3 cycles, with start and mem_ready toggling -> all outputs 0, state IDLE; no mem_req.
2. start; pc = 0x0, 0x4 ... until cycle 20, then pc = 0x100 constantly; memory returns 1..8 with mem_ready tied high; expected_sum = 36 -> mem_addr = 0x00, 0x04 ... 0x1C; sum = 36; done = 1, pass = 1, timed_out = 0; cycle_count = 24.
3. Same as 2 but expected_sum = 35 -> done = 1, pass = 0, sum = 36.
4. pc never equals END_PC, TIMEOUT = 1000 -> done after 1000 RUN cycles; timed_out = 1, pass = 0, mem_req never asserted, cycle_count = 999.
5. mem_ready low for 2 cycles per word -> mem_req and mem_addr stay stable while waiting; final sum = 36; scan takes 24 cycles.
6. Reset asserted during SCAN after 3 words; then restart with start -> outputs cleared asynchronously; the second run gives sum = 36, pass = 1. Also: start pulsed during RUN is ignored, with no counter clear.

Source files
------------

// File: rtl/program_run_checker.sv
// Run checker beside the core: counts RUN cycles, spots a halt or timeout,
// then scans the result buffer through a read handshake and grades the sum.
module program_run_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int CYCLE_WIDTH = 16,
  parameter int TIMEOUT     = 1000,
  parameter int STALL_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] END_PC   = 32'h0000_0100,
  parameter logic [ADDR_WIDTH-1:0] BUF_BASE = 32'h0000_0000,
  parameter int BUF_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready,
  input  logic [DATA_WIDTH-1:0]  mem_data,
  input  logic [DATA_WIDTH-1:0]  expected_sum,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic [DATA_WIDTH-1:0]  sum
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int IW = $clog2(BUF_DEPTH + 1);

  localparam logic [CYCLE_WIDTH-1:0] TO_LAST =
    CYCLE_WIDTH'(TIMEOUT - 1);
  localparam logic [CYCLE_WIDTH-1:0] CMAX = '1;
  localparam logic [SW-1:0] SLIM = SW'(STALL_LIMIT);
  localparam logic [IW-1:0] ILAST = IW'(BUF_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SCAN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [SW-1:0]         stall;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] exp_q;

  logic at_end;
  logic halt;
  logic tmo;
  logic accept;
  logic fire;
  logic last;
  logic [DATA_WIDTH-1:0] sum_n;

  assign at_end = (pc == END_PC);
  assign halt   = (stall == SLIM);
  assign tmo    = (cycle_count == TO_LAST);
  assign accept = start && (state == IDLE || state == DONE);
  assign fire   = mem_req && mem_ready;
  assign last   = (idx == ILAST);
  assign sum_n  = sum + mem_data;

  // Next-state selection; a halt seen in the timeout cycle wins.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (halt)     state_n = SCAN;
        else if (tmo) state_n = DONE;
      end
      SCAN: if (fire && last) state_n = DONE;
      DONE: if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Counters, scan datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
      sum         <= '0;
      stall       <= '0;
      idx         <= '0;
      exp_q       <= '0;
    end else begin
      busy <= (state_n == RUN) || (state_n == SCAN);
      done <= (state_n == DONE);
      if (accept) begin
        cycle_count <= '0;
        sum         <= '0;
        stall       <= '0;
        idx         <= '0;
        pass        <= 1'b0;
        timed_out   <= 1'b0;
        mem_req     <= 1'b0;
        exp_q       <= expected_sum;
      end
      unique case (state)
        RUN: begin
          if (halt) begin
            if (cycle_count != CMAX)
              cycle_count <= cycle_count + 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= BUF_BASE;
            idx      <= '0;
          end else if (tmo) begin
            timed_out <= 1'b1;
            pass      <= 1'b0;
          end else begin
            if (cycle_count != CMAX)
              cycle_count <= cycle_count + 1'b1;
            stall <= at_end ? stall + 1'b1 : '0;
          end
        end
        SCAN: begin
          if (fire) begin
            sum      <= sum_n;
            idx      <= idx + 1'b1;
            mem_addr <= mem_addr + STEP;
            if (last) begin
              mem_req <= 1'b0;
              pass    <= (sum_n == exp_q) && !timed_out;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_run_checker.sv
// Directed bench for program_run_checker: halt, mismatch, timeout,
// wait-state memory and mid-scan reset, with hand-computed results.
module tb_program_run_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data;
  logic [31:0] expected_sum = '0;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timed_out;
  logic [15:0] cycle_count;
  logic [31:0] sum;

  int n_chk = 0;
  int n_fail = 0;

  int wait_n = 0;
  int wcnt = 0;
  int reqcyc = 0;
  int unstable = 0;
  bit prev_wait = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] addrs[$];

  program_run_checker dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pc(pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_data(mem_data),
    .expected_sum(expected_sum),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timed_out(timed_out),
    .cycle_count(cycle_count),
    .sum(sum)
  );

  always #5 clk = ~clk;

  // buffer word k holds k+1
  assign mem_data = (mem_addr >> 2) + 32'd1;

  // memory responder: wait_n idle cycles before each accept
  always @(negedge clk) begin
    if (!reset) begin
      mem_ready = ~mem_ready;
      wcnt = 0;
      prev_wait = 0;
    end else if (mem_req) begin
      reqcyc++;
      if (prev_wait && mem_addr != prev_addr) unstable++;
      if (wcnt == wait_n) begin
        mem_ready = 1'b1;
        wcnt = 0;
        addrs.push_back(mem_addr);
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
      prev_wait = !mem_ready;
      prev_addr = mem_addr;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
      prev_wait = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pulse start, then feed pc per RUN cycle until done (or abort)
  task automatic run(input logic [31:0] e, input bit halt,
                     input bit poke, input int abort_at,
                     output int cyc);
    @(negedge clk);
    expected_sum = e;
    start = 1'b1;
    addrs.delete();
    reqcyc = 0;
    unstable = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      pc = (halt && cyc >= 19) ? 32'h100 : 32'(cyc * 4);
      start = (poke && cyc == 5);
      @(negedge clk);
      cyc++;
      if (done) break;
      if (abort_at != 0 && addrs.size() == abort_at) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;

    // 1: reset held with start toggling
    repeat (3) begin
      @(negedge clk);
      start = ~start;
    end
    #1;
    chk("rst_flags", {mem_req, busy, done, pass, timed_out}, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_sum", sum, 0);
    chk("rst_addr", mem_addr, 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;

    // 2: halt, zero-wait memory, matching sum
    wait_n = 0;
    run(36, 1, 0, 0, cyc);
    chk("t2_done", done, 1);
    chk("t2_latency", cyc, 32);
    chk("t2_sum", sum, 36);
    chk("t2_pass", pass, 1);
    chk("t2_tmo", timed_out, 0);
    chk("t2_busy", busy, 0);
    chk("t2_cycles", cycle_count, 24);
    chk("t2_reqcyc", reqcyc, 8);
    chk("t2_nwords", addrs.size(), 8);
    for (int k = 0; k < 8 && k < addrs.size(); k++)
      chk($sformatf("t2_addr%0d", k), addrs[k], 32'(4 * k));

    // 3: same run, wrong reference
    run(35, 1, 0, 0, cyc);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_sum", sum, 36);

    // 4: no halt, timeout
    run(36, 0, 0, 0, cyc);
    chk("t4_done", done, 1);
    chk("t4_latency", cyc, 1000);
    chk("t4_tmo", timed_out, 1);
    chk("t4_pass", pass, 0);
    chk("t4_cycles", cycle_count, 999);
    chk("t4_reqcyc", reqcyc, 0);
    chk("t4_sum", sum, 0);

    // 5: two wait cycles per word
    wait_n = 2;
    run(36, 1, 0, 0, cyc);
    chk("t5_done", done, 1);
    chk("t5_sum", sum, 36);
    chk("t5_pass", pass, 1);
    chk("t5_scan", reqcyc, 24);
    chk("t5_stable", unstable, 0);
    chk("t5_last_addr", addrs[$], 32'h1c);
    wait_n = 0;

    // 6: reset during scan after 3 words, then restart
    run(36, 1, 0, 3, cyc);
    chk("t6_scanning", mem_req, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_flags", {mem_req, busy, done, pass, timed_out}, 0);
    chk("t6_rst_sum", sum, 0);
    chk("t6_rst_cycles", cycle_count, 0);
    chk("t6_rst_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    run(36, 1, 1, 0, cyc);
    chk("t6_done", done, 1);
    chk("t6_sum", sum, 36);
    chk("t6_pass", pass, 1);
    chk("t6_cycles", cycle_count, 24);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
